mod_transition_scheduler: RTL and testbench

- Sequences the modulation datapath's two-segment buffer.
- Consumes the modulation settings bundle (per-segment cycle, divider and repeat count, plus a requested read segment with transition mode/value).
- Decides when the active read segment switches and counts finite repetitions, asserting STOP when they are exhausted.
- Sits between the settings decoder and the modulation index generator; drives the active segment's CYCLE/FREQ_DIV to that generator.

---
 rtl/mod_transition_scheduler_pkg.sv | 48 ++++
 rtl/mod_transition_scheduler_gpio_edge_sync.sv | 32 +++
 rtl/mod_transition_scheduler.sv | 186 ++++++++++++++++++
 tb/tb_mod_transition_scheduler.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_transition_scheduler_pkg.sv
// Shared types and constants for the modulation segment transition scheduler.
// The settings bundle, transition mode encodings and scheduler FSM states live here.
package mod_transition_scheduler_pkg;

    localparam int CYCLE_W    = 15;
    localparam int FREQ_DIV_W = 32;
    localparam int REP_W      = 32;
    localparam int VALUE_W    = 64;

    localparam logic [7:0] TRANSITION_MODE_SYNC_IDX  = 8'h00;
    localparam logic [7:0] TRANSITION_MODE_SYS_TIME  = 8'h01;
    localparam logic [7:0] TRANSITION_MODE_GPIO      = 8'h02;
    localparam logic [7:0] TRANSITION_MODE_EXT       = 8'h03;
    localparam logic [7:0] TRANSITION_MODE_IMMEDIATE = 8'hFF;

    localparam logic [REP_W-1:0] REP_INFINITE = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        RUN,
        WAIT_SYNC,
        WAIT_TIME,
        WAIT_GPIO,
        EXT
    } sched_state_e;

    typedef struct packed {
        logic                        update;
        logic                        req_rd_segment;
        logic [7:0]                  transition_mode;
        logic [VALUE_W-1:0]          transition_value;
        logic [1:0][CYCLE_W-1:0]     cycle;
        logic [1:0][FREQ_DIV_W-1:0]  freq_div;
        logic [1:0][REP_W-1:0]       rep;
    } mod_settings_t;

    // GPIO mode is only a legal request when the synchroniser is built in.
    function automatic logic mode_supported(input logic [7:0] mode, input logic gpio_en);
        case (mode)
            TRANSITION_MODE_SYNC_IDX,
            TRANSITION_MODE_SYS_TIME,
            TRANSITION_MODE_EXT,
            TRANSITION_MODE_IMMEDIATE: return 1'b1;
            TRANSITION_MODE_GPIO:      return gpio_en;
            default:                   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mod_transition_scheduler_gpio_edge_sync.sv
// Two-flop synchroniser plus rising-edge detector for each external trigger pin.
// An edge on a pin shows on rise_o two clocks after it is first sampled.
module gpio_edge_sync
    import mod_transition_scheduler_pkg::*;
#(
    parameter int GPIO_NUM = 4
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [GPIO_NUM-1:0] gpio_i,
    output logic [GPIO_NUM-1:0] rise_o
);

    logic [GPIO_NUM-1:0] meta_q;
    logic [GPIO_NUM-1:0] sync_q;
    logic [GPIO_NUM-1:0] prev_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= gpio_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/mod_transition_scheduler.sv
// Chooses the active read segment of the two-segment modulation buffer and counts repeats.
// Define MOD_TRANSITION_GPIO_EN to support GPIO-triggered transitions (mode 0x02).
module mod_transition_scheduler
    import mod_transition_scheduler_pkg::*;
#(
    parameter int SYS_TIME_W = 64,
    parameter int GPIO_NUM   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  mod_settings_t         mod_settings_i,
    input  logic [SYS_TIME_W-1:0] sys_time_i,
    input  logic                  loop_done_i,
    input  logic [GPIO_NUM-1:0]   gpio_in_i,
    output logic                  segment_o,
    output logic [CYCLE_W-1:0]    cycle_o,
    output logic [FREQ_DIV_W-1:0] freq_div_o,
    output logic                  stop_o,
    output logic                  pending_o,
    output logic                  switched_o,
    output logic                  invalid_req_o
);

`ifdef MOD_TRANSITION_GPIO_EN
    localparam logic GPIO_EN = 1'b1;
`else
    localparam logic GPIO_EN = 1'b0;
`endif

    sched_state_e          state_q, state_d;
    logic                  segment_q, segment_d;
    logic                  stop_q, stop_d;
    logic [REP_W-1:0]      rep_cnt_q, rep_cnt_d;
    logic                  target_q, target_d;
    logic [SYS_TIME_W-1:0] value_q, value_d;
    logic                  switched_q, switched_d;
    logic                  invalid_q, invalid_d;

    logic                  do_switch;
    logic                  switch_seg;
    sched_state_e          switch_state;
    logic [REP_W-1:0]      cur_rep;
    logic                  gpio_hit;

`ifdef MOD_TRANSITION_GPIO_EN
    logic [1:0]            pin_q, pin_d;
    logic [GPIO_NUM-1:0]   gpio_rise;

    gpio_edge_sync #(
        .GPIO_NUM (GPIO_NUM)
    ) u_gpio_edge_sync (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .gpio_i  (gpio_in_i),
        .rise_o  (gpio_rise)
    );

    assign gpio_hit = |(gpio_rise & (GPIO_NUM'(1) << pin_q));
`else
    logic                  gpio_unused;

    assign gpio_unused = ^gpio_in_i;
    assign gpio_hit    = 1'b0;
`endif

    assign cur_rep = mod_settings_i.rep[segment_q];

    always_comb begin
        state_d      = state_q;
        segment_d    = segment_q;
        stop_d       = stop_q;
        rep_cnt_d    = rep_cnt_q;
        target_d     = target_q;
        value_d      = value_q;
        switched_d   = 1'b0;
        invalid_d    = 1'b0;
        do_switch    = 1'b0;
        switch_seg   = target_q;
        switch_state = RUN;
`ifdef MOD_TRANSITION_GPIO_EN
        pin_d        = pin_q;
`endif

        // Repeat counting on the active segment; exhaustion stops playback or, in EXT, flips segment.
        if (loop_done_i && (cur_rep != REP_INFINITE) && !stop_q) begin
            if (rep_cnt_q == cur_rep) begin
                if (state_q == EXT) begin
                    do_switch    = 1'b1;
                    switch_seg   = ~segment_q;
                    switch_state = EXT;
                end else begin
                    stop_d = 1'b1;
                end
            end else begin
                rep_cnt_d = rep_cnt_q + 32'd1;
            end
        end

        case (state_q)
            WAIT_SYNC: do_switch = loop_done_i;
            WAIT_TIME: do_switch = (sys_time_i >= value_q);
            WAIT_GPIO: do_switch = gpio_hit;
            default:   ;
        endcase

        // A fresh request overrides whatever switch the previous request would have taken.
        if (mod_settings_i.update) begin
            if (mode_supported(mod_settings_i.transition_mode, GPIO_EN)) begin
                target_d  = mod_settings_i.req_rd_segment;
                value_d   = mod_settings_i.transition_value[SYS_TIME_W-1:0];
                do_switch = 1'b0;
`ifdef MOD_TRANSITION_GPIO_EN
                pin_d     = mod_settings_i.transition_value[1:0];
`endif
                case (mod_settings_i.transition_mode)
                    TRANSITION_MODE_SYNC_IDX: state_d = WAIT_SYNC;
                    TRANSITION_MODE_SYS_TIME: state_d = WAIT_TIME;
`ifdef MOD_TRANSITION_GPIO_EN
                    TRANSITION_MODE_GPIO:     state_d = WAIT_GPIO;
`endif
                    TRANSITION_MODE_EXT: begin
                        do_switch    = 1'b1;
                        switch_seg   = mod_settings_i.req_rd_segment;
                        switch_state = EXT;
                    end
                    default: begin
                        do_switch    = 1'b1;
                        switch_seg   = mod_settings_i.req_rd_segment;
                        switch_state = RUN;
                    end
                endcase
            end else begin
                invalid_d = 1'b1;
            end
        end

        if (do_switch) begin
            segment_d  = switch_seg;
            switched_d = 1'b1;
            stop_d     = 1'b0;
            rep_cnt_d  = '0;
            state_d    = switch_state;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= RUN;
            segment_q  <= 1'b0;
            stop_q     <= 1'b0;
            rep_cnt_q  <= '0;
            target_q   <= 1'b0;
            value_q    <= '0;
            switched_q <= 1'b0;
            invalid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            segment_q  <= segment_d;
            stop_q     <= stop_d;
            rep_cnt_q  <= rep_cnt_d;
            target_q   <= target_d;
            value_q    <= value_d;
            switched_q <= switched_d;
            invalid_q  <= invalid_d;
        end
    end

`ifdef MOD_TRANSITION_GPIO_EN
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pin_q <= 2'd0;
        end else begin
            pin_q <= pin_d;
        end
    end
`endif

    assign segment_o     = segment_q;
    assign cycle_o       = mod_settings_i.cycle[segment_q];
    assign freq_div_o    = mod_settings_i.freq_div[segment_q];
    assign stop_o        = stop_q;
    assign pending_o     = (state_q == WAIT_SYNC) || (state_q == WAIT_TIME) || (state_q == WAIT_GPIO);
    assign switched_o    = switched_q;
    assign invalid_req_o = invalid_q;

endmodule

// File: tb/tb_mod_transition_scheduler.sv
// Directed self-checking bench for mod_transition_scheduler.
// GPIO steps follow MOD_TRANSITION_GPIO_EN the same way the design does.
module tb_mod_transition_scheduler;
    import mod_transition_scheduler_pkg::*;

    logic          clk;
    logic          rst_n;
    mod_settings_t settings;
    logic [63:0]   sys_time;
    logic          loop_done;
    logic [3:0]    gpio;
    logic          segment;
    logic [14:0]   cycle;
    logic [31:0]   freq_div;
    logic          stop;
    logic          pending;
    logic          switched;
    logic          invalid_req;

    int total = 0;
    int bad   = 0;

    mod_transition_scheduler #(
        .SYS_TIME_W (64),
        .GPIO_NUM   (4)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .mod_settings_i (settings),
        .sys_time_i     (sys_time),
        .loop_done_i    (loop_done),
        .gpio_in_i      (gpio),
        .segment_o      (segment),
        .cycle_o        (cycle),
        .freq_div_o     (freq_div),
        .stop_o         (stop),
        .pending_o      (pending),
        .switched_o     (switched),
        .invalid_req_o  (invalid_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Holds UPDATE for exactly one sampling edge, then returns just after it.
    task automatic applyStimulus(input logic [7:0] mode, input logic seg, input logic [63:0] value);
        settings.update           = 1'b1;
        settings.transition_mode  = mode;
        settings.req_rd_segment   = seg;
        settings.transition_value = value;
        tick(1);
        settings.update = 1'b0;
    endtask

    task automatic loopPulse();
        loop_done = 1'b1;
        tick(1);
        loop_done = 1'b0;
    endtask

    initial begin
        rst_n                     = 1'b0;
        settings                  = '0;
        settings.cycle[0]         = 15'h0123;
        settings.cycle[1]         = 15'h0456;
        settings.freq_div[0]      = 32'h0000_1000;
        settings.freq_div[1]      = 32'h0000_2000;
        settings.rep[0]           = REP_INFINITE;
        settings.rep[1]           = REP_INFINITE;
        sys_time                  = 64'd0;
        loop_done                 = 1'b0;
        gpio                      = 4'h0;

        tick(2);
        checkOutput("rst_segment", 64'(segment), 64'd0);
        checkOutput("rst_stop", 64'(stop), 64'd0);
        checkOutput("rst_pending", 64'(pending), 64'd0);
        checkOutput("rst_switched", 64'(switched), 64'd0);
        checkOutput("rst_invalid", 64'(invalid_req), 64'd0);
        checkOutput("rst_cycle", 64'(cycle), 64'h0123);
        checkOutput("rst_freq_div", 64'(freq_div), 64'h1000);
        rst_n = 1'b1;
        tick(1);

        $display("[TB] immediate switch to segment 1");
        applyStimulus(TRANSITION_MODE_IMMEDIATE, 1'b1, 64'd0);
        checkOutput("imm_segment", 64'(segment), 64'd1);
        checkOutput("imm_switched", 64'(switched), 64'd1);
        checkOutput("imm_cycle", 64'(cycle), 64'h0456);
        checkOutput("imm_freq_div", 64'(freq_div), 64'h2000);
        tick(1);
        checkOutput("imm_switched_drop", 64'(switched), 64'd0);

        $display("[TB] sync-index switch to segment 0");
        applyStimulus(TRANSITION_MODE_SYNC_IDX, 1'b0, 64'd0);
        checkOutput("sync_pending", 64'(pending), 64'd1);
        checkOutput("sync_hold_segment", 64'(segment), 64'd1);
        tick(9);
        checkOutput("sync_pending_late", 64'(pending), 64'd1);
        loopPulse();
        checkOutput("sync_segment", 64'(segment), 64'd0);
        checkOutput("sync_switched", 64'(switched), 64'd1);
        checkOutput("sync_pending_clr", 64'(pending), 64'd0);

        $display("[TB] sys-time switch at 1000");
        sys_time = 64'd990;
        applyStimulus(TRANSITION_MODE_SYS_TIME, 1'b1, 64'd1000);
        checkOutput("time_pending", 64'(pending), 64'd1);
        for (int t = 991; t <= 1000; t++) begin
            sys_time = 64'(t);
            checkOutput("time_wait_segment", 64'(segment), 64'd0);
            tick(1);
        end
        sys_time = 64'd1001;
        checkOutput("time_segment", 64'(segment), 64'd1);
        checkOutput("time_switched", 64'(switched), 64'd1);
        applyStimulus(TRANSITION_MODE_SYS_TIME, 1'b0, 64'd500);
        checkOutput("past_pending", 64'(pending), 64'd1);
        checkOutput("past_hold_segment", 64'(segment), 64'd1);
        tick(1);
        checkOutput("past_segment", 64'(segment), 64'd0);
        checkOutput("past_switched", 64'(switched), 64'd1);

        $display("[TB] finite repeats on segment 0");
        settings.rep[0] = 32'd2;
        loopPulse();
        checkOutput("rep_stop_1", 64'(stop), 64'd0);
        tick(2);
        loopPulse();
        checkOutput("rep_stop_2", 64'(stop), 64'd0);
        tick(2);
        loopPulse();
        checkOutput("rep_stop_3", 64'(stop), 64'd1);
        loopPulse();
        checkOutput("rep_stop_hold", 64'(stop), 64'd1);
        applyStimulus(TRANSITION_MODE_IMMEDIATE, 1'b0, 64'd0);
        checkOutput("rep_stop_clr", 64'(stop), 64'd0);
        checkOutput("rep_same_seg_switched", 64'(switched), 64'd1);
        checkOutput("rep_same_seg", 64'(segment), 64'd0);

        $display("[TB] external auto-toggle");
        settings.rep[0] = 32'd0;
        settings.rep[1] = 32'd1;
        applyStimulus(TRANSITION_MODE_EXT, 1'b0, 64'd0);
        checkOutput("ext_enter_switched", 64'(switched), 64'd1);
        checkOutput("ext_enter_pending", 64'(pending), 64'd0);
        loopPulse();
        checkOutput("ext_seg_1", 64'(segment), 64'd1);
        checkOutput("ext_sw_1", 64'(switched), 64'd1);
        loopPulse();
        checkOutput("ext_seg_2", 64'(segment), 64'd1);
        checkOutput("ext_sw_2", 64'(switched), 64'd0);
        loopPulse();
        checkOutput("ext_seg_3", 64'(segment), 64'd0);
        checkOutput("ext_stop_3", 64'(stop), 64'd0);
        loopPulse();
        checkOutput("ext_seg_4", 64'(segment), 64'd1);
        checkOutput("ext_stop_4", 64'(stop), 64'd0);
        settings.rep[0] = REP_INFINITE;
        settings.rep[1] = REP_INFINITE;
        applyStimulus(TRANSITION_MODE_IMMEDIATE, 1'b0, 64'd0);
        checkOutput("ext_leave_segment", 64'(segment), 64'd0);

        $display("[TB] unknown mode rejected");
        applyStimulus(8'h07, 1'b1, 64'd0);
        checkOutput("bad_mode_invalid", 64'(invalid_req), 64'd1);
        checkOutput("bad_mode_segment", 64'(segment), 64'd0);
        checkOutput("bad_mode_pending", 64'(pending), 64'd0);
        tick(1);
        checkOutput("bad_mode_invalid_drop", 64'(invalid_req), 64'd0);

`ifdef MOD_TRANSITION_GPIO_EN
        $display("[TB] gpio pin 2 trigger");
        applyStimulus(TRANSITION_MODE_GPIO, 1'b1, 64'd2);
        checkOutput("gpio_pending", 64'(pending), 64'd1);
        gpio[0] = 1'b1;
        tick(4);
        checkOutput("gpio_wrong_pin", 64'(segment), 64'd0);
        gpio[2] = 1'b1;
        tick(2);
        checkOutput("gpio_early", 64'(segment), 64'd0);
        tick(1);
        checkOutput("gpio_segment", 64'(segment), 64'd1);
        checkOutput("gpio_switched", 64'(switched), 64'd1);
        gpio = 4'h0;
        applyStimulus(TRANSITION_MODE_IMMEDIATE, 1'b0, 64'd0);
`else
        $display("[TB] gpio mode rejected");
        gpio[2] = 1'b1;
        applyStimulus(TRANSITION_MODE_GPIO, 1'b1, 64'd2);
        checkOutput("gpio_invalid", 64'(invalid_req), 64'd1);
        checkOutput("gpio_pending", 64'(pending), 64'd0);
        tick(4);
        checkOutput("gpio_segment", 64'(segment), 64'd0);
        gpio = 4'h0;
`endif

        $display("[TB] new request beats coincident loop end");
        applyStimulus(TRANSITION_MODE_SYNC_IDX, 1'b1, 64'd0);
        loop_done = 1'b1;
        applyStimulus(TRANSITION_MODE_SYNC_IDX, 1'b1, 64'd0);
        loop_done = 1'b0;
        checkOutput("race_segment", 64'(segment), 64'd0);
        checkOutput("race_switched", 64'(switched), 64'd0);
        checkOutput("race_pending", 64'(pending), 64'd1);
        loopPulse();
        checkOutput("race_later_segment", 64'(segment), 64'd1);

        $display("[TB] reset during a wait");
        applyStimulus(TRANSITION_MODE_SYNC_IDX, 1'b0, 64'd0);
        checkOutput("rstw_pending", 64'(pending), 64'd1);
        rst_n = 1'b0;
        #1;
        checkOutput("rstw_pending_clr", 64'(pending), 64'd0);
        checkOutput("rstw_segment", 64'(segment), 64'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);
        loopPulse();
        checkOutput("rstw_no_switch", 64'(switched), 64'd0);
        checkOutput("rstw_still_idle", 64'(pending), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
